// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the issue front-end and the iterative multiply/divide unit.
// The front-end drives the operation fields; the unit returns status and writeback data.
interface muldiv_unit_if;
  logic        start;
  logic        op;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [3:0]  dest;
  logic        flush;
  logic        busy;
  logic        done;
  logic [15:0] resLo;
  logic [15:0] resHi;
  logic [3:0]  wbDest;
  logic [1:0]  regWrite;

  modport master (
    output start, op, opA, opB, dest, flush,
    input  busy, done, resLo, resHi, wbDest, regWrite
  );

  modport slave (
    input  start, op, opA, opB, dest, flush,
    output busy, done, resLo, resHi, wbDest, regWrite
  );
endinterface

// File: rtl/muldiv_unit.sv
// 16x16 unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Results are written back through a one-cycle DONE pulse.
module muldiv_unit (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q;
  logic        op_q;
  logic [15:0] b_q;        // multiplicand (multiply) or divisor (divide)
  logic [16:0] hi_q;       // product high half or partial remainder
  logic [15:0] lo_q;       // multiplier / product low half, or dividend / quotient
  logic [4:0]  count_q;
  logic [3:0]  dest_q;
  logic [15:0] res_lo_q;
  logic [15:0] res_hi_q;
  logic [3:0]  wb_dest_q;

  logic [16:0] mul_sum;
  logic [16:0] div_shift;
  logic [17:0] div_trial;
  logic [16:0] hi_d;
  logic [15:0] lo_d;

  // One iteration of whichever algorithm is in flight.
  always_comb begin
    mul_sum   = {1'b0, hi_q[15:0]} + (lo_q[0] ? {1'b0, b_q} : 17'd0);
    div_shift = {hi_q[15:0], lo_q[15]};
    div_trial = {1'b0, div_shift} - {2'b00, b_q};
    if (op_q) begin
      if (!div_trial[17]) begin
        hi_d = div_trial[16:0];
        lo_d = {lo_q[14:0], 1'b1};
      end else begin
        hi_d = div_shift;
        lo_d = {lo_q[14:0], 1'b0};
      end
    end else begin
      hi_d = {1'b0, mul_sum[16:1]};
      lo_d = {mul_sum[0], lo_q[15:1]};
    end
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values,
  // and the datapath is reset too because it is small and keeps the outputs defined.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      dest_q    <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      wb_dest_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q    <= bus.op;
            b_q     <= bus.op ? bus.opB : bus.opA;
            lo_q    <= bus.op ? bus.opA : bus.opB;
            hi_q    <= '0;
            dest_q  <= bus.dest;
            count_q <= 5'd16;
            if (bus.op && (bus.opB == 16'd0)) begin
              res_lo_q  <= 16'hFFFF;
              res_hi_q  <= bus.opA;
              wb_dest_q <= bus.dest;
              state_q   <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_q - 5'd1;
            if (count_q == 5'd1) begin
              res_lo_q  <= lo_d;
              res_hi_q  <= hi_d[15:0];
              wb_dest_q <= dest_q;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          count_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush during DONE must squash the writeback in the same cycle.
  assign bus.done     = (state_q == DONE) && !bus.flush;
  assign bus.regWrite = bus.done ? 2'd2 : 2'd0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.resLo    = res_lo_q;
  assign bus.resHi    = res_hi_q;
  assign bus.wbDest   = wb_dest_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued operations queue their expected results,
// and a monitor compares every done pulse against the queue head.
module tb_muldiv_unit;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  dest;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands, timing from the accept edge.
  function automatic exp_t model(input bit o, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] d, input int acc);
    exp_t        e;
    logic [31:0] p;
    e.dest = d;
    if (!o) begin
      p     = 32'(a) * 32'(b);
      e.lo  = p[15:0];
      e.hi  = p[31:16];
      e.due = acc + 16;
    end else if (b == 16'd0) begin
      e.lo  = 16'hFFFF;
      e.hi  = a;
      e.due = acc;
    end else begin
      e.lo  = a / b;
      e.hi  = a % b;
      e.due = acc + 16;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, bus.done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("res_lo", {16'd0, bus.resLo}, {16'd0, e.lo});
        check("res_hi", {16'd0, bus.resHi}, {16'd0, e.hi});
        check("wb_dest", {28'd0, bus.wbDest}, {28'd0, e.dest});
        check("regwrite_done", {30'd0, bus.regWrite}, 32'd2);
        check("done_cycle", cyc, e.due);
        last = e;
      end
    end else begin
      check("regwrite_idle", {30'd0, bus.regWrite}, 32'd0);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_regwrite"}, {30'd0, bus.regWrite}, 32'd0);
    check({tag, "_reslo"}, {16'd0, bus.resLo}, 32'd0);
    check({tag, "_reshi"}, {16'd0, bus.resHi}, 32'd0);
    check({tag, "_wbdest"}, {28'd0, bus.wbDest}, 32'd0);
  endtask

  // Waits for IDLE, presents one request, returns the accept edge index.
  task automatic issue(input bit o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d, input bit push, output int acc);
    @(negedge clk);
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    if (bus.busy) check("idle_timeout", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opA   = a;
    bus.opB   = b;
    bus.dest  = d;
    @(posedge clk);
    #1;
    acc       = cyc;
    bus.start = 1'b0;
    if (push) sb.push_back(model(o, a, b, d, acc));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin
    int          acc;
    bit          o;
    logic [15:0] a, b;
    logic [3:0]  d;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    bus.dest  = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // First start lands on the first edge with reset released.
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.opA   = 16'hFF0F;
    bus.opB   = 16'h0F00;
    bus.dest  = 4'd3;
    @(posedge clk);
    #1;
    acc       = cyc;
    bus.start = 1'b0;
    sb.push_back(model(1'b0, 16'hFF0F, 16'h0F00, 4'd3, acc));
    check("first_accept_busy", {31'd0, bus.busy}, 32'd1);
    wait_drain();
    check("mul_known_lo", {16'd0, bus.resLo}, 32'hE100);
    check("mul_known_hi", {16'd0, bus.resHi}, 32'h0EF1);

    issue(1'b1, 16'hAAAA, 16'h0024, 4'd8, 1'b1, acc);
    wait_drain();
    check("div_known_lo", {16'd0, bus.resLo}, 32'h04BD);
    check("div_known_hi", {16'd0, bus.resHi}, 32'h0016);

    issue(1'b1, 16'h00FF, 16'h0000, 4'd5, 1'b1, acc);
    wait_drain();
    check("div0_lo", {16'd0, bus.resLo}, 32'hFFFF);
    check("div0_hi", {16'd0, bus.resHi}, 32'h00FF);

    // Start held high: ignored while busy and in DONE, re-accepted in the next IDLE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.opA   = 16'h1234;
    bus.opB   = 16'h5678;
    bus.dest  = 4'd7;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(model(1'b0, 16'h1234, 16'h5678, 4'd7, acc));
    check("held_busy_0", {31'd0, bus.busy}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      check("held_busy", {31'd0, bus.busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    check("held_idle_after_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    check("held_second_accept", {31'd0, bus.busy}, 32'd1);
    sb.push_back(model(1'b0, 16'h1234, 16'h5678, 4'd7, cyc));
    bus.start = 1'b0;
    wait_drain();

    repeat (40) begin
      o = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'd0;
        1, 2:    b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      d = 4'($urandom);
      issue(o, a, b, d, 1'b1, acc);
    end
    wait_drain();

    // Flush in RUN cycle 8: no writeback, results untouched.
    issue(1'b0, 16'hBEEF, 16'h1357, 4'd9, 1'b0, acc);
    repeat (7) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_run_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_run_idle", {31'd0, bus.busy}, 32'd0);
    repeat (25) @(posedge clk);
    #1;
    check("flush_keep_lo", {16'd0, bus.resLo}, {16'd0, last.lo});
    check("flush_keep_hi", {16'd0, bus.resHi}, {16'd0, last.hi});
    check("flush_keep_dest", {28'd0, bus.wbDest}, {28'd0, last.dest});

    // Flush during DONE squashes the pulse in that same cycle.
    issue(1'b1, 16'h9999, 16'h0033, 4'd4, 1'b0, acc);
    repeat (16) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_done_busy", {31'd0, bus.busy}, 32'd1);
    check("flush_done_pulse", {31'd0, bus.done}, 32'd0);
    check("flush_done_regwrite", {30'd0, bus.regWrite}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_done_idle", {31'd0, bus.busy}, 32'd0);

    // Flush wins over start in IDLE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_priority", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (20) @(posedge clk);

    // Reset in RUN cycle 5 aborts without writeback.
    issue(1'b0, 16'h7777, 16'h3333, 4'd6, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midrun_reset");
    reset = 1'b1;
    issue(1'b0, 16'h00FF, 16'h0101, 4'd2, 1'b1, acc);
    wait_drain();
    check("post_reset_lo", {16'd0, bus.resLo}, 32'hFFFF);
    check("post_reset_hi", {16'd0, bus.resHi}, 32'h0000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port start, input, 1, request a new operation, sampled in IDLE only.
REQ-004 SHALL have port op, input, 1, 0 = unsigned multiply, 1 = unsigned divide.
REQ-005 SHALL have port opA, input, 16, multiplicand or dividend.
REQ-006 SHALL have port opB, input, 16, multiplier or divisor.
REQ-007 SHALL have port dest, input, 4, writeback register index for the low result.
REQ-008 SHALL have port flush, input, 1, abort the in-flight operation without writeback.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE; front-end stall.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resLo, output, 16, product[15:0] or quotient; feeds register-file dataW.
REQ-012 SHALL have port resHi, output, 16, product[31:16] or remainder; feeds register-file R0.
REQ-013 SHALL have port wbDest, output, 4, captured dest; feeds register-file FWriteback.
REQ-014 SHALL have port regWrite, output, 2, writeback code: 0 = none, 2 = write dest and R0.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE with start=1 SHALL capture op, opA, opB and dest, then go to RUN (or DONE for divide-by-zero); the iteration count SHALL load 16.
REQ-017 start while state is not IDLE SHALL be ignored; no queueing.
REQ-018 Multiply SHALL be shift-add, one bit per cycle, 16 RUN cycles, full 32-bit product with no truncation.
REQ-019 Divide SHALL be restoring, one quotient bit per cycle, 16 RUN cycles, 17-bit partial remainder.
REQ-020 RUN SHALL decrement the count each cycle and go to DONE when the count reaches 0.
REQ-021 Latency: start accepted at edge N SHALL give done=1 in the cycle after edge N+16.
REQ-022 Divide with opB=0 SHALL skip RUN and go IDLE->DONE in one cycle, with resLo=16'hFFFF and resHi=opA.
REQ-023 DONE SHALL last exactly one cycle, with done=1 and regWrite=2, then return to IDLE.
REQ-024 regWrite SHALL be 0 and done SHALL be 0 in every state other than DONE.
REQ-025 resLo, resHi and wbDest SHALL be valid in DONE and SHALL hold until the next DONE.
REQ-026 In DONE, start=1 SHALL be ignored; the earliest next accept is the following IDLE cycle.
REQ-027 flush=1 in RUN or DONE SHALL force IDLE next cycle, force regWrite=0 and done=0 in the current cycle, and leave resLo/resHi unchanged.
REQ-028 flush and start high together in IDLE SHALL give flush priority; the start is not accepted.

Reset
REQ-029 reset=0 at a rising edge SHALL force state IDLE, count 0, busy 0, done 0, regWrite 0, resLo 0, resHi 0, wbDest 0.
REQ-030 reset SHALL override start and flush, and SHALL abort a RUN in progress with no writeback.
REQ-031 The first start SHALL be accepted at the first edge with reset=1.

Verification
REQ-032 Multiply: op=0, opA=16'hFF0F, opB=16'h0F00, dest=3 -> done after 17 cycles with resLo=16'hE100, resHi=16'h0EF1, wbDest=3, regWrite=2 for one cycle.
REQ-033 Divide: op=1, opA=16'hAAAA, opB=16'h0024, dest=8 -> resLo=16'h04BD, resHi=16'h0016, regWrite=2.
REQ-034 Divide by zero: op=1, opA=16'h00FF, opB=0 -> done in the cycle after accept with resLo=16'hFFFF and resHi=16'h00FF.
REQ-035 Start held high throughout a multiply -> exactly one done pulse; the second op is accepted only after return to IDLE; busy stays high across all 17 cycles.
REQ-036 flush at RUN cycle 8 -> no done, regWrite stays 0, IDLE next cycle, previous results retained.
REQ-037 reset=0 at RUN cycle 5 -> all outputs 0 next cycle, and a fresh multiply 16'h00FF x 16'h0101 gives resLo=16'hFFFF, resHi=0.
